apb_reg_completer: RTL

//  APB3 completer (responder) for one PSEL slice of the apb_if bus: a bank of NUM_REGS 32-bit RW registers.

---
 rtl/apb_reg_completer.sv | 102 ++++++++++
 1 files changed

// File: rtl/apb_reg_completer.sv
// APB3 completer exposing a bank of NUM_REGS 32-bit read/write registers.
// Inserts WAIT_STATES access-phase wait cycles and flags bad addresses with PSLVERR.
// Register contents are exported in parallel on regs_o for the configured block.
module apb_reg_completer #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PADDR,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int         IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              done;
  logic [31:0]       rd_word;

  // Address decode from the live bus; the initiator holds PADDR stable for the whole transfer.
  assign idx = PADDR[2 +: IDX_W];
  assign err = (|PADDR[1:0]) || (PADDR[31:2] >= 30'(NUM_REGS));

  // Completion is combinational so PREADY drops the instant reset is asserted.
  assign done    = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == WS) && !PRESET;
  assign PREADY  = done;
  assign PSLVERR = done && err;
  assign PRDATA  = (done && !PWRITE && !err) ? rd_word : 32'h0;

  // Read mux with a bounds guard for non-power-of-two register counts.
  always_comb begin
    rd_word = 32'h0;
    if (32'(idx) < NUM_REGS) rd_word = regs_q[idx];
  end

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: setup enters ACCESS, PSEL loss aborts, wait count then complete.
  // NOTE: defaults come first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q == WS) state_d = IDLE;
          else             cnt_d   = 4'(cnt_q + 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register bank: written at the completing edge of an error-free write.
  // NOTE: this storage is reset explicitly because downstream logic relies on RESET_VAL after reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (done && PWRITE && !err && (32'(idx) < NUM_REGS)) begin
      regs_q[idx] <= PWDATA;
    end
  end

  // Flatten the bank onto the parallel export port.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule
